swd_host: RTL and testbench

- SWD initiator engine: the probe-side end of the SWD link that the SoC debug port responds to.
- Converts a single-transaction request/response interface into SWD bit sequences on SWDCLK/SWDIO. Covers request, turnaround, ACK, data and parity phases, plus line reset.
- Sits in FPGA bench/probe builds. SWDOUT/SWDOE/SWDIN feed a top-level tristate on the shared SWDIO pad.

---
 rtl/swd_pkg.sv | 24 ++
 rtl/swd_clkgen.sv | 36 +++
 rtl/swd_host.sv | 150 +++++++++++++++
 tb/tb_swd_host.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/swd_pkg.sv
// Shared SWD host definitions: ACK codes, engine state encoding and the request-byte builder.
package swd_pkg;

    localparam logic [2:0] ACK_OK    = 3'b001;
    localparam logic [2:0] ACK_WAIT  = 3'b010;
    localparam logic [2:0] ACK_FAULT = 3'b100;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_REQ    = 4'd1;
    localparam logic [3:0] ST_TRN    = 4'd2;
    localparam logic [3:0] ST_ACK    = 4'd3;
    localparam logic [3:0] ST_RDATA  = 4'd4;
    localparam logic [3:0] ST_WDATA  = 4'd5;
    localparam logic [3:0] ST_LRESET = 4'd6;
    localparam logic [3:0] ST_TAIL   = 4'd7;
    localparam logic [3:0] ST_DONE   = 4'd8;

    // Bit 0 goes on the wire first: start, APnDP, RnW, A2, A3, parity, stop, park.
    function automatic logic [7:0] req_byte(input logic apndp, input logic rnw,
                                            input logic [1:0] addr);
        return {1'b1, 1'b0, apndp ^ rnw ^ addr[0] ^ addr[1], addr[1], addr[0], rnw, apndp, 1'b1};
    endfunction

endpackage

// File: rtl/swd_clkgen.sv
// SWDCLK generator: one bit is CLK_DIV cycles low then CLK_DIV cycles high while run is set.
module swd_clkgen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic CLK,
    input  logic RESET,
    input  logic run,
    output logic SWDCLK,
    output logic bit_start,
    output logic sample
);

    localparam int unsigned CW = $clog2(2 * CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] SAMP = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge CLK) begin
        if (RESET || !run) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign SWDCLK    = run && (cnt_q >= HALF);
    assign sample    = run && (cnt_q == SAMP);
    // Strobes on the final cycle of a bit, so state stepped on it is live from the next bit's
    // first low cycle.
    assign bit_start = run && (cnt_q == LAST);

endmodule

// File: rtl/swd_host.sv
// SWD initiator: turns one request into the SWD request/turnaround/ACK/data/parity sequence.
module swd_host
    import swd_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned IDLE_BITS   = 8,
    parameter int unsigned LRESET_BITS = 56
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_lreset,
    input  logic        req_apndp,
    input  logic        req_rnw,
    input  logic [1:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [2:0]  rsp_ack,
    output logic [31:0] rsp_rdata,
    output logic        rsp_perr,
    output logic        SWDCLK,
    output logic        SWDOUT,
    output logic        SWDOE,
    input  logic        SWDIN
);

    logic [3:0]  state_q, state_d;
    logic [7:0]  bitcnt_q, phase_len;
    logic [32:0] sh_q;
    logic [31:0] wdata_q, rsp_rdata_q;
    logic [2:0]  ack_q, rsp_ack_q;
    logic        rnw_q, lreset_q, ack_seen_q, rsp_perr_q;
    logic        run, bit_start, sample, last_bit, accept, ack_ok, rd_ok;

    assign run       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign accept    = req_valid && req_ready;
    assign ack_ok    = (ack_q == ACK_OK);
    assign rd_ok     = rnw_q && !lreset_q && ack_ok;
    assign last_bit  = bit_start && (bitcnt_q == phase_len - 8'd1);
    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_DONE);
    assign rsp_ack   = rsp_ack_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_perr  = rsp_perr_q;

    swd_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .CLK       (CLK),
        .RESET     (RESET),
        .run       (run),
        .SWDCLK    (SWDCLK),
        .bit_start (bit_start),
        .sample    (sample)
    );

    always_comb begin
        phase_len = 8'd1;
        case (state_q)
            ST_REQ:             phase_len = 8'd8;
            ST_ACK:             phase_len = 8'd3;
            ST_RDATA, ST_WDATA: phase_len = 8'd33;
            ST_LRESET:          phase_len = 8'(LRESET_BITS);
            ST_TAIL:            phase_len = 8'(IDLE_BITS);
            default:            phase_len = 8'd1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = req_lreset ? ST_LRESET : ST_REQ;
            ST_REQ:    if (last_bit) state_d = ST_TRN;
            // The first turnaround leads to ACK; the one after ACK leads to write data or tail.
            ST_TRN:    if (last_bit) state_d = !ack_seen_q ? ST_ACK :
                                               (!rnw_q && ack_ok) ? ST_WDATA : ST_TAIL;
            ST_ACK:    if (last_bit) state_d = (rnw_q && ack_ok) ? ST_RDATA : ST_TRN;
            ST_RDATA:  if (last_bit) state_d = ST_TRN;
            ST_WDATA:  if (last_bit) state_d = ST_TAIL;
            ST_LRESET: if (last_bit) state_d = ST_TAIL;
            ST_TAIL:   if (last_bit) state_d = ST_DONE;
            ST_DONE:   if (rsp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            bitcnt_q    <= '0;
            sh_q        <= '0;
            wdata_q     <= '0;
            ack_q       <= '0;
            ack_seen_q  <= 1'b0;
            rnw_q       <= 1'b0;
            lreset_q    <= 1'b0;
            rsp_ack_q   <= '0;
            rsp_rdata_q <= '0;
            rsp_perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (last_bit) begin
                bitcnt_q <= '0;
            end else if (bit_start) begin
                bitcnt_q <= bitcnt_q + 8'd1;
            end
            if (accept) begin
                rnw_q      <= req_rnw;
                lreset_q   <= req_lreset;
                wdata_q    <= req_wdata;
                sh_q       <= {25'd0, req_byte(req_apndp, req_rnw, req_addr)};
                ack_q      <= '0;
                ack_seen_q <= 1'b0;
            end
            case (state_q)
                ST_REQ, ST_WDATA: if (bit_start) sh_q <= {1'b0, sh_q[32:1]};
                ST_ACK: begin
                    if (sample) ack_q <= {SWDIN, ack_q[2:1]};
                    if (last_bit) ack_seen_q <= 1'b1;
                end
                ST_TRN:   if (last_bit && state_d == ST_WDATA) sh_q <= {^wdata_q, wdata_q};
                ST_RDATA: if (sample) sh_q <= {SWDIN, sh_q[32:1]};
                ST_TAIL: if (last_bit) begin
                    rsp_ack_q   <= ack_q;
                    rsp_rdata_q <= rd_ok ? sh_q[31:0] : 32'd0;
                    rsp_perr_q  <= rd_ok && ((^sh_q[31:0]) != sh_q[32]);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        SWDOE  = 1'b0;
        SWDOUT = 1'b0;
        case (state_q)
            ST_REQ, ST_WDATA: begin
                SWDOE  = 1'b1;
                SWDOUT = sh_q[0];
            end
            ST_LRESET: begin
                SWDOE  = 1'b1;
                SWDOUT = 1'b1;
            end
            ST_TAIL: SWDOE = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_swd_host.sv
// Bench for swd_host: a bit-level SWD target model plus expected wire sequences built from the
// protocol's phase layout.
`timescale 1ns/1ps
module tb_swd_host;
    import swd_pkg::*;

    localparam int CLK_DIV     = 4;
    localparam int IDLE_BITS   = 8;
    localparam int LRESET_BITS = 56;

    logic        CLK = 1'b0, RESET = 1'b1;
    logic        req_valid = 1'b0, req_lreset = 1'b0, req_apndp = 1'b0, req_rnw = 1'b0;
    logic [1:0]  req_addr = 2'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_ready = 1'b0, SWDIN = 1'b1;
    logic        req_ready, rsp_valid, rsp_perr, SWDCLK, SWDOUT, SWDOE;
    logic [2:0]  rsp_ack;
    logic [31:0] rsp_rdata;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 CLK = ~CLK;

    swd_host #(.CLK_DIV(CLK_DIV), .IDLE_BITS(IDLE_BITS), .LRESET_BITS(LRESET_BITS)) dut (
        .CLK(CLK), .RESET(RESET), .req_valid(req_valid), .req_ready(req_ready),
        .req_lreset(req_lreset), .req_apndp(req_apndp), .req_rnw(req_rnw), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ack(rsp_ack),
        .rsp_rdata(rsp_rdata), .rsp_perr(rsp_perr), .SWDCLK(SWDCLK), .SWDOUT(SWDOUT),
        .SWDOE(SWDOE), .SWDIN(SWDIN)
    );

    // Runs one transaction up to rsp_valid, acting as the target, and checks wire and response.
    task automatic do_txn(input string name, input bit lrst, input bit ap, input bit rnw,
                          input bit [1:0] addr, input bit [31:0] wd, input bit [2:0] ack,
                          input bit [31:0] rd, input bit flip, input bit [8:0] chk_rb,
                          output bit [2:0] e_ack, output bit [31:0] e_rdata, output bit e_perr);
        bit req_bits[$], exp_oe[$], exp_out[$], got_oe[$], got_out[$], tgt[$];
        bit ok_rd, ok_wr, prev;
        int cyc, nbad, first_bad;
        bit [7:0] got_rb, exp_rb;
        ok_rd   = !lrst && ack == ACK_OK && rnw;
        ok_wr   = !lrst && ack == ACK_OK && !rnw;
        e_ack   = lrst ? 3'b000 : ack;
        e_rdata = ok_rd ? rd : 32'd0;
        e_perr  = ok_rd && flip;
        req_bits.push_back(1'b1);
        req_bits.push_back(ap);
        req_bits.push_back(rnw);
        req_bits.push_back(addr[0]);
        req_bits.push_back(addr[1]);
        req_bits.push_back(ap ^ rnw ^ addr[0] ^ addr[1]);
        req_bits.push_back(1'b0);
        req_bits.push_back(1'b1);
        if (lrst) begin
            for (int i = 0; i < LRESET_BITS; i++) begin exp_oe.push_back(1); exp_out.push_back(1); end
        end else begin
            for (int i = 0; i < 8; i++) begin exp_oe.push_back(1); exp_out.push_back(req_bits[i]); end
            for (int i = 0; i < 4; i++) begin exp_oe.push_back(0); exp_out.push_back(0); end
            if (ok_rd) begin
                for (int i = 0; i < 34; i++) begin exp_oe.push_back(0); exp_out.push_back(0); end
            end else if (ok_wr) begin
                exp_oe.push_back(0); exp_out.push_back(0);
                for (int i = 0; i < 32; i++) begin exp_oe.push_back(1); exp_out.push_back(wd[i]); end
                exp_oe.push_back(1); exp_out.push_back(^wd);
            end else begin
                exp_oe.push_back(0); exp_out.push_back(0);
            end
        end
        for (int i = 0; i < IDLE_BITS; i++) begin exp_oe.push_back(1); exp_out.push_back(0); end
        for (int i = 0; i < exp_oe.size(); i++) tgt.push_back(1'b1);
        if (!lrst) for (int i = 0; i < 3; i++) tgt[9 + i] = ack[i];
        if (ok_rd) begin
            for (int i = 0; i < 32; i++) tgt[12 + i] = rd[i];
            tgt[44] = (^rd) ^ flip;
        end

        @(negedge CLK);
        req_valid = 1; req_lreset = lrst; req_apndp = ap; req_rnw = rnw; req_addr = addr;
        req_wdata = wd; SWDIN = tgt[0];
        @(negedge CLK);
        req_valid = 0;
        tests_run++;
        if (req_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s req_ready_after_accept: got %b want 0", name, req_ready);
        end
        prev = 0;
        cyc = 0;
        while (rsp_valid !== 1'b1 && cyc < 4000) begin
            @(negedge CLK);
            cyc++;
            if (SWDCLK === 1'b1 && !prev) begin
                got_oe.push_back(SWDOE);
                got_out.push_back(SWDOUT);
                SWDIN = (got_oe.size() < tgt.size()) ? tgt[got_oe.size()] : 1'b1;
            end
            prev = (SWDCLK === 1'b1);
        end
        tests_run++;
        if (rsp_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s timeout: rsp_valid %b after %0d cycles, want 1", name, rsp_valid, cyc);
            return;
        end
        tests_run++;
        if (got_oe.size() != exp_oe.size()) begin
            tests_failed++;
            $display("FAIL %s pulses: got %0d want %0d", name, got_oe.size(), exp_oe.size());
        end
        nbad = 0;
        first_bad = -1;
        for (int i = 0; i < exp_oe.size() && i < got_oe.size(); i++) begin
            if (got_oe[i] !== exp_oe[i] || (exp_oe[i] && got_out[i] !== exp_out[i])) begin
                if (nbad == 0) first_bad = i;
                nbad++;
            end
        end
        tests_run++;
        if (nbad != 0) begin
            tests_failed++;
            $display("FAIL %s bitseq: %0d bad bits, first at bit %0d oe/out got %b/%b want %b/%b",
                     name, nbad, first_bad, got_oe[first_bad], got_out[first_bad],
                     exp_oe[first_bad], exp_out[first_bad]);
        end
        if (!lrst && got_out.size() >= 8) begin
            for (int i = 0; i < 8; i++) begin got_rb[i] = got_out[i]; exp_rb[i] = req_bits[i]; end
            tests_run++;
            if (got_rb !== exp_rb) begin
                tests_failed++;
                $display("FAIL %s req_byte: got %h want %h", name, got_rb, exp_rb);
            end
            if (chk_rb[8]) begin
                tests_run++;
                if (got_rb !== chk_rb[7:0]) begin
                    tests_failed++;
                    $display("FAIL %s req_byte_const: got %h want %h", name, got_rb, chk_rb[7:0]);
                end
            end
        end
        tests_run++;
        if (SWDCLK !== 1'b0 || req_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s done_lines: SWDCLK %b req_ready %b want 0 0", name, SWDCLK, req_ready);
        end
        tests_run++;
        if (rsp_ack !== e_ack || rsp_rdata !== e_rdata || rsp_perr !== e_perr) begin
            tests_failed++;
            $display("FAIL %s rsp: ack %b rdata %h perr %b want %b %h %b", name, rsp_ack,
                     rsp_rdata, rsp_perr, e_ack, e_rdata, e_perr);
        end
    endtask

    task automatic consume(input string name);
        @(negedge CLK);
        rsp_ready = 1;
        @(negedge CLK);
        rsp_ready = 0;
        tests_run++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s consume: req_ready %b rsp_valid %b want 1 0", name, req_ready, rsp_valid);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK);
        RESET = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            tests_run++;
            if (SWDCLK !== 0 || SWDOE !== 0 || SWDOUT !== 0 || req_ready !== 1 || rsp_valid !== 0 ||
                rsp_ack !== 3'd0 || rsp_rdata !== 32'd0 || rsp_perr !== 0) begin
                tests_failed++;
                $display("FAIL reset_values: clk %b oe %b out %b rdy %b vld %b ack %b rd %h perr %b",
                         SWDCLK, SWDOE, SWDOUT, req_ready, rsp_valid, rsp_ack, rsp_rdata, rsp_perr);
            end
        end
    endtask

    task automatic test_directed();
        bit [2:0] a; bit [31:0] d; bit p;
        do_txn("idcode", 0, 0, 1, 2'b00, 0, ACK_OK, 32'h2BA01477, 0, 9'h1A5, a, d, p);
        consume("idcode");
        do_txn("select", 0, 0, 0, 2'b10, 32'h000000F0, ACK_OK, 0, 0, 9'h1B1, a, d, p);
        consume("select");
        do_txn("ap_wait", 0, 1, 1, 2'b01, 0, ACK_WAIT, 32'hDEADBEEF, 0, 9'h0, a, d, p);
        consume("ap_wait");
        do_txn("lreset", 1, 0, 0, 2'b00, 0, 3'b000, 0, 0, 9'h0, a, d, p);
        consume("lreset");
        do_txn("bad_parity", 0, 0, 1, 2'b00, 0, ACK_OK, 32'h2BA01477, 1, 9'h0, a, d, p);
        consume("bad_parity");
    endtask

    task automatic test_random();
        bit [2:0] acks[6];
        bit [2:0] a; bit [31:0] d; bit p;
        acks = '{ACK_OK, ACK_OK, ACK_WAIT, ACK_FAULT, 3'b000, 3'b111};
        for (int n = 0; n < 24; n++) begin
            do_txn("random", $urandom_range(0, 7) == 0, 1'($urandom), 1'($urandom),
                   2'($urandom), $urandom, acks[$urandom_range(0, 5)], $urandom,
                   1'($urandom), 9'h0, a, d, p);
            consume("random");
        end
    endtask

    task automatic test_hold_and_reset();
        bit [2:0] ea; bit [31:0] ed; bit ep;
        do_txn("hold", 0, 1, 1, 2'($urandom), 0, ACK_OK, $urandom, 1'($urandom), 9'h0, ea, ed, ep);
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            tests_run++;
            if (rsp_valid !== 1 || req_ready !== 0 || rsp_ack !== ea || rsp_rdata !== ed ||
                rsp_perr !== ep) begin
                tests_failed++;
                $display("FAIL hold_stable: vld %b rdy %b ack %b rd %h perr %b want 1 0 %b %h %b",
                         rsp_valid, req_ready, rsp_ack, rsp_rdata, rsp_perr, ea, ed, ep);
            end
        end
        consume("hold");
        @(negedge CLK);
        req_valid = 1; req_lreset = 0; req_apndp = 0; req_rnw = 1; req_addr = 2'b00;
        @(negedge CLK);
        req_valid = 0;
        repeat (3 * 2 * CLK_DIV) @(negedge CLK);
        tests_run++;
        if (SWDOE !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreq_busy: SWDOE %b want 1", SWDOE);
        end
        RESET = 1;
        @(negedge CLK);
        RESET = 0;
        tests_run++;
        if (SWDOE !== 0 || SWDCLK !== 0 || req_ready !== 1 || rsp_valid !== 0) begin
            tests_failed++;
            $display("FAIL midreq_reset: oe %b clk %b rdy %b vld %b want 0 0 1 0",
                     SWDOE, SWDCLK, req_ready, rsp_valid);
        end
        repeat (2 * CLK_DIV) @(negedge CLK);
        tests_run++;
        if (SWDCLK !== 0 || SWDOE !== 0) begin
            tests_failed++;
            $display("FAIL post_reset_idle: clk %b oe %b want 0 0", SWDCLK, SWDOE);
        end
        do_txn("recover", 0, 0, 1, 2'b00, 0, ACK_OK, 32'h2BA01477, 0, 9'h1A5, ea, ed, ep);
        consume("recover");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_hold_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
